ext_unit_pipe: RTL and testbench
================================

// Module: ext_unit_pipe
// PURPOSE
// - Parametrised, pipelined successor of the combinational zero-extender: widens an IN_W-bit
//   immediate to OUT_W bits in one of four modes, behind a valid/ready handshake.
// - Sits between instruction decode and the ALU operand mux; a 2-entry skid buffer
//   absorbs ALU back-pressure without a combinational ready path.
// PARAMETERS
// - IN_W   4  input immediate width, 1..OUT_W-1
// - OUT_W  8  output operand width
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      upstream immediate valid
// - in_ready   out  1      block can accept; registered, no comb path from out_ready
// - in_data    in   IN_W   immediate
// - in_mode    in   2      00 zero-ext, 01 sign-ext, 10 ones-fill, 11 high-place
// - out_valid  out  1      extended operand valid
// - out_ready  in   1      downstream accepts
// - out_data   out  OUT_W  extended operand
// - out_neg    out  1      MSB of out_data (operand sign), registered with out_data
// BEHAVIOUR
// - Reset (async, rst_n=0): out_valid=0, out_data=0, out_neg=0, in_ready=1, skid empty.
//   Reset mid-transfer discards all held data; no partial output after release.
// - Accept when in_valid & in_ready; Deliver when out_valid & out_ready.
// - Extension (combinational on accept, registered):
//   00: {(OUT_W-IN_W)'b0, in_data}; 01: {(OUT_W-IN_W){in_data[IN_W-1]}, in_data};
//   10: {(OUT_W-IN_W)'b1, in_data}; 11: see CONFIGURATION.
// - Latency: accept in cycle N -> out_valid=1 with data in cycle N+1 (main reg empty).
// - States (held-entry count): EMPTY(0), ONE(1, main reg), FULL(2, main + skid).
//   EMPTY: accept -> ONE.
//   ONE: accept & deliver -> ONE (main reloads); accept only -> FULL (new word to skid);
//        deliver only -> EMPTY.
//   FULL: in_ready=0; deliver -> ONE, skid moves to main; no accept possible.
// - in_ready = (state != FULL), registered; deasserts the cycle after entering FULL.
// - Order strictly FIFO; no word dropped or duplicated; out_data stable while
//   out_valid & !out_ready.
// - in_data/in_mode ignored when not accepted; out_data holds last value when out_valid=0.
// - Mode and data captured together; mode change between words has no cross effect.
// CONFIGURATION
// - Macro EXT_HI_MODE_EN.
// - Defined: mode 11 = {in_data, (OUT_W-IN_W)'b0} (load-upper style), out_neg=in_data[IN_W-1].
// - Undefined: mode 11 behaves exactly as mode 00 (zero-extend); no extra logic built.
// TESTING (IN_W=4, OUT_W=8)
// - Reset: rst_n=0 mid-stream with FULL -> out_valid=0, out_data=8'h00, in_ready=1
//   immediately, nothing emitted after release.
// - Modes, out_ready=1: 4'b0011 m00 -> 8'h03; 4'b1100 m00 -> 8'h0C; 4'b1100 m01 -> 8'hFC,
//   out_neg=1; 4'b0011 m10 -> 8'hF3; each one cycle after accept.
// - Mode 11, 4'b1010: with EXT_HI_MODE_EN -> 8'hA0, out_neg=1; without -> 8'h0A, out_neg=0.
// - Back-pressure: out_ready=0, push 4'h1,4'h2 m00 -> FULL, in_ready=0; then out_ready=1
//   -> 8'h01 then 8'h02 in order, in_ready=1 after first deliver.
// - Stream: in_valid=1, out_ready=1, 16 words 4'h0..4'hF m01 -> 16 outputs, one per cycle,
//   8'h00..8'h07 then 8'hF8..8'hFF, no bubbles.
// - Random valid/ready toggling 1000 words vs reference model -> exact order and values.

Source files
------------

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: pipelined IN_W->OUT_W immediate extender with 2-entry skid buffer; EXT_HI_MODE_EN enables mode 11 high-place
module ext_unit_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);
  localparam int PW = OUT_W - IN_W;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [OUT_W-1:0] ext, main_q, skid_q;
  logic acc, dlv, load_main, load_skid, main_from_skid;
  assign acc       = in_valid & in_ready;
  assign dlv       = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign out_neg   = main_q[OUT_W-1];
  // widen the incoming immediate according to its mode
  always_comb begin
`ifdef EXT_HI_MODE_EN
    ext = in_mode == 2'b01 ? {{PW{in_data[IN_W-1]}}, in_data} :
          in_mode == 2'b10 ? {{PW{1'b1}}, in_data} :
          in_mode == 2'b11 ? {in_data, {PW{1'b0}}} :
                             {{PW{1'b0}}, in_data};
`else
    ext = in_mode == 2'b01 ? {{PW{in_data[IN_W-1]}}, in_data} :
          in_mode == 2'b10 ? {{PW{1'b1}}, in_data} :
                             {{PW{1'b0}}, in_data};
`endif
  end
  // occupancy next-state and register load selects
  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        state_nx  = ONE;
        load_main = 1'b1;
      end
      ONE: if (acc && dlv) load_main = 1'b1;
      else if (acc) begin
        state_nx  = FULL;
        load_skid = 1'b1;
      end
      else if (dlv) state_nx = EMPTY;
      FULL: if (dlv) begin
        state_nx       = ONE;
        main_from_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end
  // occupancy register; in_ready is registered from the next occupancy so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= state_nx != FULL;
    end
  end
  // main output register and skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_from_skid) main_q <= skid_q;
      else if (load_main) main_q <= ext;
      if (load_skid) skid_q <= ext;
    end
  end
endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb_ext_unit_pipe: directed and randomized checks of ext_unit_pipe at IN_W=4, OUT_W=8
module tb_ext_unit_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_neg;
  logic [3:0] in_data = '0;
  logic [1:0] in_mode = '0;
  logic [7:0] out_data;
  int checks = 0, failures = 0;

  ext_unit_pipe #(.IN_W(4), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [3:0] d, input logic [1:0] m);
    case (m)
      2'b00: return {4'h0, d};
      2'b01: return d[3] ? {4'hF, d} : {4'h0, d};
      2'b10: return {4'hF, d};
`ifdef EXT_HI_MODE_EN
      default: return {d, 4'h0};
`else
      default: return {4'h0, d};
`endif
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_neg !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%h neg=%b ready=%b, want 0 00 0 1", out_valid, out_data, out_neg, in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_modes();
    logic [3:0] d [5];
    logic [1:0] m [5];
    logic [7:0] e [5];
    logic       n [5];
    d = '{4'b0011, 4'b1100, 4'b1100, 4'b0011, 4'b1010};
    m = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
`ifdef EXT_HI_MODE_EN
    e = '{8'h03, 8'h0C, 8'hFC, 8'hF3, 8'hA0};
    n = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    e = '{8'h03, 8'h0C, 8'hFC, 8'hF3, 8'h0A};
    n = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      in_mode  = m[i];
      step();
      in_valid = 1'b0;
      in_data  = 4'h5;
      in_mode  = 2'b10;
      checks++;
      if (out_valid !== 1'b1 || out_data !== e[i] || out_neg !== n[i]) begin
        failures++;
        $display("FAIL mode_vec%0d: valid=%b data=%h neg=%b, want 1 %h %b", i, out_valid, out_data, out_neg, e[i], n[i]);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== e[i]) begin
        failures++;
        $display("FAIL mode_drain%0d: valid=%b data=%h, want 0 %h", i, out_valid, out_data, e[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_mode   = 2'b00;
    in_valid  = 1'b1;
    in_data   = 4'h1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h01) begin
      failures++;
      $display("FAIL bp_one: ready=%b valid=%b data=%h, want 1 1 01", in_ready, out_valid, out_data);
    end
    in_data = 4'h2;
    step();
    in_valid = 1'b0;
    in_data  = 4'h7;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h01) begin
      failures++;
      $display("FAIL bp_full: ready=%b valid=%b data=%h, want 0 1 01", in_ready, out_valid, out_data);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_data !== 8'h01) begin
      failures++;
      $display("FAIL bp_hold: ready=%b data=%h, want 0 01", in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h02) begin
      failures++;
      $display("FAIL bp_second: ready=%b valid=%b data=%h, want 1 1 02", in_ready, out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [7:0] e;
    out_ready = 1'b1;
    in_mode   = 2'b01;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i);
      step();
      e = i < 8 ? 8'(i) : 8'(8'hF0 + i);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream%0d: valid=%b data=%h ready=%b, want 1 %h 1", i, out_valid, out_data, in_ready, e);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_mode   = 2'b10;
    in_valid  = 1'b1;
    in_data   = 4'h3;
    step();
    in_data = 4'h4;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_full: valid=%b data=%h ready=%b, want 0 00 1", out_valid, out_data, in_ready);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_after%0d: valid=%b data=%h, want valid 0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] e, hold;
    logic       stall = 1'b0;
    int sent = 0, got = 0, cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      in_valid  = sent < 1000 && $urandom_range(0, 1) == 1;
      in_data   = 4'($urandom);
      in_mode   = 2'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold) begin
          failures++;
          $display("FAIL rand_stable: valid=%b data=%h, want 1 %h", out_valid, out_data, hold);
        end
      end
      stall = out_valid && !out_ready;
      hold  = out_data;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra: data=%h, want no output", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e || out_neg !== e[7]) begin
            failures++;
            $display("FAIL rand_word%0d: data=%h neg=%b, want %h %b", got, out_data, out_neg, e, e[7]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_mode));
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 1000 || q.size() != 0) begin
      failures++;
      $display("FAIL rand_count: delivered=%0d left=%0d, want 1000 0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_stream();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
